// File: rtl/comm_pkg.sv
// Shared constants and FSM state encoding for the host-side PUF stream interface.
package comm_pkg;

  localparam int DATA_W   = 128;
  localparam int TX_BEATS = 4;
  localparam int RX_BEATS = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    RECV = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/comm_host_if.sv
// Host side of the PUF buffer: serializes a 512-bit command MSB-first onto tx_*,
// reassembles a 384-bit response from rx_*, flags framing errors and response timeouts.
module comm_host_if
  import comm_pkg::*;
#(
  parameter int TO_W = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [DATA_W*TX_BEATS-1:0]   cmd_data,
  output logic [DATA_W-1:0]            tx_TDATA,
  output logic                         tx_TVALID,
  input  logic                         tx_TREADY,
  output logic                         tx_TLAST,
  input  logic [DATA_W-1:0]            rx_TDATA,
  input  logic                         rx_TVALID,
  output logic                         rx_TREADY,
  input  logic                         rx_TLAST,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W*RX_BEATS-1:0]   rsp_data,
  output logic                         rsp_err,
  output logic                         rsp_to,
  output logic                         busy,
  output state_t                       dbg_state
);

  localparam int CMD_W  = DATA_W * TX_BEATS;
  localparam int RSP_W  = DATA_W * RX_BEATS;
  localparam int BEAT_W = $clog2(TX_BEATS);
  localparam int RXC_W  = $clog2(RX_BEATS);
  localparam logic [BEAT_W-1:0] TX_LAST_BEAT = BEAT_W'(TX_BEATS - 1);
  localparam logic [RXC_W-1:0]  RX_LAST_BEAT = RXC_W'(RX_BEATS - 1);
  // Counter value one short of all-ones: the idle cycle that takes it to all-ones is the timeout.
  localparam logic [TO_W-1:0]   TO_PRE = {{(TO_W-1){1'b1}}, 1'b0};

  // Handshakes: a beat moves on a rising edge where both valid and ready are high.
  // tx_TVALID/tx_TDATA are pure state decodes, so they never depend on tx_TREADY.

  state_t              state, state_nxt;
  logic [CMD_W-1:0]    sreg;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [RXC_W-1:0]    rx_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [RSP_W-1:0]    rsp_q;
  logic                err_q;
  logic                to_q;
  logic                cmd_ready_q;

  logic in_rx;
  logic cmd_hs;
  logic tx_hs;
  logic rx_hs;
  logic rx_bad;
  logic to_hit;

  assign in_rx  = (state == WAIT) || (state == RECV);
  assign cmd_hs = cmd_valid && cmd_ready_q;
  assign tx_hs  = (state == SEND) && tx_TREADY;
  assign rx_hs  = in_rx && rx_TVALID;
  assign rx_bad = rx_hs && (rx_TLAST != (rx_cnt == RX_LAST_BEAT));
  assign to_hit = in_rx && !rx_TVALID && (to_cnt == TO_PRE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_hs) state_nxt = SEND;
      SEND: if (tx_hs && (beat_cnt == TX_LAST_BEAT)) state_nxt = WAIT;
      WAIT, RECV: begin
        if (rx_hs) begin
          if (rx_TLAST || (rx_cnt == RX_LAST_BEAT)) state_nxt = DONE;
          else                                      state_nxt = RECV;
        end else if (to_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is a register so that it reads 0 while reset is asserted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      sreg        <= '0;
      beat_cnt    <= '0;
      rx_cnt      <= '0;
      rsp_q       <= '0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready_q <= (state_nxt == IDLE);
      if (cmd_hs) begin
        sreg     <= cmd_data;
        beat_cnt <= '0;
        rx_cnt   <= '0;
        rsp_q    <= '0;
        err_q    <= 1'b0;
        to_q     <= 1'b0;
      end
      if (tx_hs) begin
        sreg     <= sreg << DATA_W;
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
      if (rx_hs) begin
        rsp_q  <= {rsp_q[RSP_W-DATA_W-1:0], rx_TDATA};
        rx_cnt <= rx_cnt + RXC_W'(1);
      end
      if (rx_bad) err_q <= 1'b1;
      if (to_hit) to_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (rx_hs || ((state == SEND) && (state_nxt == WAIT))) begin
      to_cnt <= '0;
    end else if (in_rx) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign tx_TVALID = (state == SEND);
  assign tx_TDATA  = sreg[CMD_W-1 -: DATA_W];
  assign tx_TLAST  = (state == SEND) && (beat_cnt == TX_LAST_BEAT);
  assign rx_TREADY = in_rx;
  assign rsp_valid = (state == DONE);
  assign rsp_data  = rsp_q;
  assign rsp_err   = err_q;
  assign rsp_to    = to_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_comm_host_if.sv
// Directed bench for comm_host_if: command serialization, stalls, response framing,
// timeouts (16-bit and 4-bit counters) and asynchronous reset mid-send.
module tb_comm_host_if;
  import comm_pkg::*;

  logic          clk = 1'b0;
  logic          resetn, s_resetn;
  logic          cmd_valid;
  logic [511:0]  cmd_data;
  logic          tx_TREADY;
  logic [127:0]  rx_TDATA;
  logic          rx_TVALID, rx_TLAST;
  logic          rsp_ready;

  logic          cmd_ready, tx_TVALID, tx_TLAST, rx_TREADY;
  logic [127:0]  tx_TDATA;
  logic          rsp_valid, rsp_err, rsp_to, busy;
  logic [383:0]  rsp_data;
  state_t        dbg_state;

  logic          s_cmd_ready, s_tx_TVALID, s_tx_TLAST, s_rx_TREADY;
  logic [127:0]  s_tx_TDATA;
  logic          s_rsp_valid, s_rsp_err, s_rsp_to, s_busy;
  logic [383:0]  s_rsp_data;
  state_t        s_dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  comm_host_if #(.TO_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .tx_TDATA(tx_TDATA), .tx_TVALID(tx_TVALID), .tx_TREADY(tx_TREADY),
    .tx_TLAST(tx_TLAST), .rx_TDATA(rx_TDATA), .rx_TVALID(rx_TVALID), .rx_TREADY(rx_TREADY),
    .rx_TLAST(rx_TLAST), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_to(rsp_to), .busy(busy), .dbg_state(dbg_state)
  );

  comm_host_if #(.TO_W(4)) u_small (
    .clk(clk), .resetn(s_resetn), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_data(cmd_data), .tx_TDATA(s_tx_TDATA), .tx_TVALID(s_tx_TVALID), .tx_TREADY(tx_TREADY),
    .tx_TLAST(s_tx_TLAST), .rx_TDATA(rx_TDATA), .rx_TVALID(rx_TVALID), .rx_TREADY(s_rx_TREADY),
    .rx_TLAST(rx_TLAST), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
    .rsp_err(s_rsp_err), .rsp_to(s_rsp_to), .busy(s_busy), .dbg_state(s_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [511:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    tx_TREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full command with tx_TREADY held high; checks every beat in consecutive cycles.
  task automatic run_tx(input string tag, input logic [511:0] d);
    send_cmd(d);
    chk({tag, "_err_clr"}, 384'(rsp_err), 384'(0));
    chk({tag, "_rsp_clr"}, rsp_data, 384'(0));
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_valid"}, 384'(tx_TVALID), 384'(1));
      chk({tag, "_data"}, 384'(tx_TDATA), 384'(d[511-128*b -: 128]));
      chk({tag, "_last"}, 384'(tx_TLAST), 384'(b == 3));
      chk({tag, "_busy"}, 384'(busy), 384'(1));
      chk({tag, "_cready"}, 384'(cmd_ready), 384'(0));
      tick();
    end
    chk({tag, "_wait_tv"}, 384'(tx_TVALID), 384'(0));
    chk({tag, "_wait_rr"}, 384'(rx_TREADY), 384'(1));
  endtask

  task automatic rx_beat(input logic [127:0] d, input logic last);
    rx_TVALID = 1'b1;
    rx_TDATA  = d;
    rx_TLAST  = last;
    tick();
    rx_TVALID = 1'b0;
    rx_TLAST  = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [511:0] d1, d2, d4, d6a, d6b;
    logic [127:0] prev_data;
    logic         prev_stall;
    int           hs;
    int           n;

    d1  = {{4{32'hAAAAAAAA}}, {4{32'hBBBBBBBB}}, {4{32'hCCCCCCCC}}, {4{32'hDDDDDDDD}}};
    d2  = {128'h11, 128'h22, 128'h33, 128'h44};
    d4  = {128'h5, 128'h6, 128'h7, 128'h8};
    d6a = {128'hA1, 128'hA2, 128'hA3, 128'hA4};
    d6b = {128'hF1, 128'hF2, 128'hF3, 128'hF4};

    resetn = 1'b0; s_resetn = 1'b0;
    cmd_valid = 1'b0; cmd_data = '0; tx_TREADY = 1'b0;
    rx_TDATA = '0; rx_TVALID = 1'b0; rx_TLAST = 1'b0; rsp_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_cready", 384'(cmd_ready), 384'(0));
    chk("rst_busy", 384'(busy), 384'(0));
    chk("rst_tvalid", 384'(tx_TVALID), 384'(0));
    chk("rst_rvalid", 384'(rsp_valid), 384'(0));
    chk("rst_rready", 384'(rx_TREADY), 384'(0));
    resetn = 1'b1;
    tick();
    chk("idle_cready", 384'(cmd_ready), 384'(1));
    chk("idle_state", 384'(dbg_state), 384'(IDLE));

    // Command A,B,C,D back to back, then slow response with back-off
    run_tx("t1", d1);
    for (int i = 0; i < 70; i++) tick();
    chk("t3_idle_rready", 384'(rx_TREADY), 384'(1));
    chk("t3_idle_rvalid", 384'(rsp_valid), 384'(0));
    rx_beat(128'h1, 1'b0);
    rx_beat(128'h2, 1'b0);
    rx_beat(128'h3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 384'(rsp_valid), 384'(1));
      chk("t3_hold_data", rsp_data, {128'h1, 128'h2, 128'h3});
      tick();
    end
    chk("t3_err", 384'(rsp_err), 384'(0));
    chk("t3_to", 384'(rsp_to), 384'(0));
    chk("t3_done_rready", 384'(rx_TREADY), 384'(0));
    finish_rsp();
    chk("t3_rvalid_fall", 384'(rsp_valid), 384'(0));
    chk("t3_idle_cready", 384'(cmd_ready), 384'(1));
    chk("t3_idle_busy", 384'(busy), 384'(0));

    // Random tx_TREADY stalls
    send_cmd(d2);
    tx_TREADY = 1'b0;
    for (int b = 0; b < 4; b++) exp_q.push_back(d2[511-128*b -: 128]);
    hs = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 60 && hs < 4; c++) begin
      if (prev_stall) begin
        chk("t2_stall_valid", 384'(tx_TVALID), 384'(1));
        chk("t2_stall_data", 384'(tx_TDATA), 384'(prev_data));
      end
      tx_TREADY = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      if (tx_TVALID && tx_TREADY) begin
        if (exp_q.size() == 0) chk("t2_extra_beat", 384'(1), 384'(0));
        else chk("t2_beat", 384'(tx_TDATA), 384'(exp_q.pop_front()));
        chk("t2_last", 384'(tx_TLAST), 384'(hs == 3));
        hs++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = tx_TVALID;
      end
      prev_data = tx_TDATA;
      tick();
    end
    tx_TREADY = 1'b0;
    chk("t2_hs_count", 384'(hs), 384'(4));
    chk("t2_q_empty", 384'(exp_q.size()), 384'(0));
    chk("t2_wait_tv", 384'(tx_TVALID), 384'(0));
    chk("t2_wait_state", 384'(dbg_state), 384'(WAIT));

    // Short frame: TLAST on the second beat
    rx_beat(128'h1, 1'b0);
    rx_beat(128'h2, 1'b1);
    chk("t4a_valid", 384'(rsp_valid), 384'(1));
    chk("t4a_err", 384'(rsp_err), 384'(1));
    chk("t4a_to", 384'(rsp_to), 384'(0));
    chk("t4a_data", rsp_data, {128'h0, 128'h1, 128'h2});
    finish_rsp();

    // Third beat without TLAST; stray command and rx beat in DONE are ignored
    run_tx("t4b", d4);
    rx_beat(128'h1, 1'b0);
    rx_beat(128'h2, 1'b0);
    rx_beat(128'h3, 1'b0);
    chk("t4b_err", 384'(rsp_err), 384'(1));
    chk("t4b_data", rsp_data, {128'h1, 128'h2, 128'h3});
    cmd_valid = 1'b1;
    rx_TVALID = 1'b1; rx_TDATA = 128'h9;
    chk("t4b_done_cready", 384'(cmd_ready), 384'(0));
    chk("t4b_done_rready", 384'(rx_TREADY), 384'(0));
    tick();
    cmd_valid = 1'b0; rx_TVALID = 1'b0;
    chk("t4b_done_state", 384'(dbg_state), 384'(DONE));
    chk("t4b_done_data", rsp_data, {128'h1, 128'h2, 128'h3});
    finish_rsp();

    // Full-width timeout with no rx traffic
    run_tx("t5a", d1);
    n = 0;
    while (!rsp_valid && n < 70000) begin
      tick();
      n++;
    end
    chk("t5a_cycles", 384'(n), 384'(65535));
    chk("t5a_to", 384'(rsp_to), 384'(1));
    chk("t5a_err", 384'(rsp_err), 384'(0));
    chk("t5a_data", rsp_data, 384'(0));
    finish_rsp();

    // 4-bit counter: a beat on the last pre-timeout cycle wins, then times out after 15
    s_resetn = 1'b1;
    tick();
    chk("t5b_s_cready", 384'(s_cmd_ready), 384'(1));
    run_tx("t5b", d2);
    for (int i = 0; i < 14; i++) tick();
    chk("t5b_pre_valid", 384'(s_rsp_valid), 384'(0));
    rx_beat(128'h7, 1'b0);
    chk("t5b_hs_valid", 384'(s_rsp_valid), 384'(0));
    chk("t5b_hs_state", 384'(s_dbg_state), 384'(RECV));
    n = 0;
    while (!s_rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t5b_cycles", 384'(n), 384'(15));
    chk("t5b_to", 384'(s_rsp_to), 384'(1));
    chk("t5b_err", 384'(s_rsp_err), 384'(0));
    chk("t5b_data", s_rsp_data, 384'(128'h7));
    finish_rsp();
    s_resetn = 1'b0;

    // Asynchronous reset during the second command beat
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    send_cmd(d6a);
    tick();
    chk("t6_beat2", 384'(tx_TDATA), 384'(128'hA2));
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_tv", 384'(tx_TVALID), 384'(0));
    chk("t6_async_td", 384'(tx_TDATA), 384'(0));
    chk("t6_async_tl", 384'(tx_TLAST), 384'(0));
    chk("t6_async_busy", 384'(busy), 384'(0));
    chk("t6_async_cready", 384'(cmd_ready), 384'(0));
    chk("t6_async_rr", 384'(rx_TREADY), 384'(0));
    tick();
    resetn = 1'b1;
    tick();
    chk("t6_cready", 384'(cmd_ready), 384'(1));
    run_tx("t6_fresh", d6b);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
